// File: rtl/reg_port_arbiter.sv
// ---------------------------------------------------------------------------
// reg_port_arbiter
//
// Shares one register-block access port between two command requesters.
// Each requester's single-cycle write/read pulse is parked in a one-entry
// pending slot; a round-robin FSM grants slots, issues the command to the
// register block and, for reads, holds the port until read data returns and
// routes it back to the requester that issued it.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> a read that sees no i_r_valid within TIMEOUT cycles of
//                waiting is answered with o_rspN_err=1 and value 0.
//   undefined -> reads wait indefinitely; o_rspN_err is tied to 0.
//
// Parameters:
//   WORD_WIDTH  address width and word width in bits
//   REG_WIDTH   register value width in words (VW = REG_WIDTH*WORD_WIDTH)
//   TIMEOUT     read-wait limit in cycles (>= 2), used with ARB_TIMEOUT_EN
//
// Ports:
//   clk, i_reset_n                 clock, async active-low reset
//   i_reqN_w_en / i_reqN_r_en      write / read request pulses (N = 0,1)
//   i_reqN_addr / i_reqN_value     request address / write data
//   o_busyN                        pending slot N occupied
//   o_dropN                        sticky: request lost because slot N was full
//   o_rspN_valid/_value/_err       read response pulse, data, timeout flag
//   o_w_en/o_w_addr/o_w_value      register-block write port
//   o_r_en/o_r_addr                register-block read port
//   i_r_value / i_r_valid          register-block read data / valid
// All outputs are registered.
// ---------------------------------------------------------------------------
module reg_port_arbiter #(
   parameter int WORD_WIDTH = 8,
   parameter int REG_WIDTH  = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                             clk,
   input  logic                             i_reset_n,
   input  logic                             i_req0_w_en,
   input  logic                             i_req0_r_en,
   input  logic [WORD_WIDTH-1:0]            i_req0_addr,
   input  logic [REG_WIDTH*WORD_WIDTH-1:0]  i_req0_value,
   input  logic                             i_req1_w_en,
   input  logic                             i_req1_r_en,
   input  logic [WORD_WIDTH-1:0]            i_req1_addr,
   input  logic [REG_WIDTH*WORD_WIDTH-1:0]  i_req1_value,
   output logic                             o_busy0,
   output logic                             o_busy1,
   output logic                             o_drop0,
   output logic                             o_drop1,
   output logic                             o_rsp0_valid,
   output logic [REG_WIDTH*WORD_WIDTH-1:0]  o_rsp0_value,
   output logic                             o_rsp0_err,
   output logic                             o_rsp1_valid,
   output logic [REG_WIDTH*WORD_WIDTH-1:0]  o_rsp1_value,
   output logic                             o_rsp1_err,
   output logic                             o_w_en,
   output logic [WORD_WIDTH-1:0]            o_w_addr,
   output logic [REG_WIDTH*WORD_WIDTH-1:0]  o_w_value,
   output logic                             o_r_en,
   output logic [WORD_WIDTH-1:0]            o_r_addr,
   input  logic [REG_WIDTH*WORD_WIDTH-1:0]  i_r_value,
   input  logic                             i_r_valid
);

   localparam int VW = REG_WIDTH * WORD_WIDTH;

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("reg_port_arbiter: TIMEOUT must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD
   } state_t;

   typedef struct packed {
      logic                  is_write;
      logic [WORD_WIDTH-1:0] addr;
      logic [VW-1:0]         value;
   } slot_t;

   // Requester inputs gathered into arrays so both slots share one code path.
   logic [1:0]            req_any;
   logic [1:0]            req_w;
   logic [WORD_WIDTH-1:0] req_addr  [2];
   logic [VW-1:0]         req_value [2];

   assign req_any      = {i_req1_w_en | i_req1_r_en, i_req0_w_en | i_req0_r_en};
   assign req_w        = {i_req1_w_en, i_req0_w_en};
   assign req_addr[0]  = i_req0_addr;
   assign req_addr[1]  = i_req1_addr;
   assign req_value[0] = i_req0_value;
   assign req_value[1] = i_req1_value;

   slot_t      slot [2];
   logic [1:0] slot_valid;
   logic [1:0] drop;

   state_t     state;
   logic       ptr;            // favoured requester when both slots are valid
   logic       owner;          // requester whose command holds the port
   logic       granted_write;
   logic [1:0] rsp_valid;
   logic [VW-1:0] rsp_value [2];

   logic       grant_any;
   logic       grant_idx;

   // Grant decision for this cycle; it only takes effect in IDLE.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 1'b0;
      if (state == IDLE && slot_valid != 2'b00) begin
         grant_any = 1'b1;
         // Both valid: pointer decides. One valid: that one (slot 1 iff slot 0 empty).
         grant_idx = (&slot_valid) ? ptr : ~slot_valid[0];
      end
   end

   // Slot occupancy and sticky drop flags. A slot being granted this cycle
   // still reads as busy, so a request arriving now is dropped.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         slot_valid <= '0;
         drop       <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (req_any[n] && slot_valid[n])
               drop[n] <= 1'b1;
            if (grant_any && grant_idx == n[0])
               slot_valid[n] <= 1'b0;
            else if (req_any[n])
               slot_valid[n] <= 1'b1;
         end
      end
   end

   // Slot payload. NOTE: the payload carries no reset; slot_valid qualifies
   // it, so reset only needs to clear the valid bits.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (req_any[n] && !slot_valid[n]) begin
            slot[n].is_write <= req_w[n];   // write wins if both enables are high
            slot[n].addr     <= req_addr[n];
            slot[n].value    <= req_value[n];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       rsp_err;
`endif

   // Arbitration FSM with registered port and response outputs.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         ptr           <= 1'b0;
         owner         <= 1'b0;
         granted_write <= 1'b0;
         o_w_en        <= 1'b0;
         o_w_addr      <= '0;
         o_w_value     <= '0;
         o_r_en        <= 1'b0;
         o_r_addr      <= '0;
         rsp_valid     <= '0;
         rsp_value[0]  <= '0;
         rsp_value[1]  <= '0;
`ifdef ARB_TIMEOUT_EN
         rsp_err       <= '0;
         wait_cnt      <= '0;
`endif
      end else begin
         // Port enables and response pulses last exactly one cycle.
         o_w_en    <= 1'b0;
         o_r_en    <= 1'b0;
         rsp_valid <= '0;
`ifdef ARB_TIMEOUT_EN
         rsp_err   <= '0;
`endif
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner         <= grant_idx;
                  ptr           <= ~grant_idx;
                  granted_write <= slot[grant_idx].is_write;
                  // Register the command now so it appears during ISSUE.
                  if (slot[grant_idx].is_write) begin
                     o_w_en    <= 1'b1;
                     o_w_addr  <= slot[grant_idx].addr;
                     o_w_value <= slot[grant_idx].value;
                  end else begin
                     o_r_en    <= 1'b1;
                     o_r_addr  <= slot[grant_idx].addr;
                  end
                  state <= ISSUE;
               end
            end

            ISSUE: begin
               state <= granted_write ? IDLE : WAIT_RD;
`ifdef ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end

            WAIT_RD: begin
               if (i_r_valid) begin
                  // Real data wins even on the expiry cycle.
                  rsp_valid[owner] <= 1'b1;
                  rsp_value[owner] <= i_r_value;
                  state            <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_valid[owner] <= 1'b1;
                  rsp_value[owner] <= '0;
                  rsp_err[owner]   <= 1'b1;
                  state            <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign o_busy0      = slot_valid[0];
   assign o_busy1      = slot_valid[1];
   assign o_drop0      = drop[0];
   assign o_drop1      = drop[1];
   assign o_rsp0_valid = rsp_valid[0];
   assign o_rsp1_valid = rsp_valid[1];
   assign o_rsp0_value = rsp_value[0];
   assign o_rsp1_value = rsp_value[1];
`ifdef ARB_TIMEOUT_EN
   assign o_rsp0_err   = rsp_err[0];
   assign o_rsp1_err   = rsp_err[1];
`else
   assign o_rsp0_err   = 1'b0;
   assign o_rsp1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_port_arbiter
//
// Self-checking bench for reg_port_arbiter. A transaction-level reference
// model tracks pending slots, the round-robin pointer and a port timeline
// (the cycle at which the port is next free, the outstanding read and its
// first waiting cycle) and predicts every output for the following cycle.
// Directed sequences cover the listed scenarios; a random phase follows.
// Honours ARB_TIMEOUT_EN (timeout scenario built with TIMEOUT = 8).
// ---------------------------------------------------------------------------
module tb_reg_port_arbiter;

   localparam int WW = 8;
   localparam int RW = 4;
   localparam int VW = WW * RW;
   localparam int TO = 8;

   typedef struct packed {
      logic          w;
      logic          r;
      logic [WW-1:0] addr;
      logic [VW-1:0] value;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_w_en, req0_r_en, req1_w_en, req1_r_en;
   logic [WW-1:0] req0_addr, req1_addr;
   logic [VW-1:0] req0_value, req1_value;
   logic          busy0, busy1, drop0, drop1;
   logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [VW-1:0] rsp0_value, rsp1_value;
   logic          w_en, r_en;
   logic [WW-1:0] w_addr, r_addr;
   logic [VW-1:0] w_value;
   logic [VW-1:0] r_value;
   logic          r_valid;

   always #5 clk = ~clk;

   reg_port_arbiter #(.WORD_WIDTH(WW), .REG_WIDTH(RW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .i_reset_n    (rst_n),
      .i_req0_w_en  (req0_w_en),
      .i_req0_r_en  (req0_r_en),
      .i_req0_addr  (req0_addr),
      .i_req0_value (req0_value),
      .i_req1_w_en  (req1_w_en),
      .i_req1_r_en  (req1_r_en),
      .i_req1_addr  (req1_addr),
      .i_req1_value (req1_value),
      .o_busy0      (busy0),
      .o_busy1      (busy1),
      .o_drop0      (drop0),
      .o_drop1      (drop1),
      .o_rsp0_valid (rsp0_valid),
      .o_rsp0_value (rsp0_value),
      .o_rsp0_err   (rsp0_err),
      .o_rsp1_valid (rsp1_valid),
      .o_rsp1_value (rsp1_value),
      .o_rsp1_err   (rsp1_err),
      .o_w_en       (w_en),
      .o_w_addr     (w_addr),
      .o_w_value    (w_value),
      .o_r_en       (r_en),
      .o_r_addr     (r_addr),
      .i_r_value    (r_value),
      .i_r_valid    (r_valid)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            cyc;
   bit            m_slot_v [2];
   bit            m_slot_w [2];
   logic [WW-1:0] m_slot_a [2];
   logic [VW-1:0] m_slot_d [2];
   bit            m_drop   [2];
   int            m_ptr;
   bit            m_rd_out;      // a read is issued and unanswered
   int            m_rd_owner;
   int            m_rd_first;    // first cycle the arbiter waits for read data
   int            m_avail_at;    // earliest cycle a new grant may be decided
   bit            e_w_en, e_r_en;
   logic [WW-1:0] e_w_addr, e_r_addr;
   logic [VW-1:0] e_w_value;
   bit            e_rsp_v   [2];
   logic [VW-1:0] e_rsp_val [2];
   bit            e_rsp_err [2];

   function automatic void model_reset();
      cyc = 0;
      for (int n = 0; n < 2; n++) begin
         m_slot_v[n] = 0; m_slot_w[n] = 0; m_slot_a[n] = '0; m_slot_d[n] = '0;
         m_drop[n] = 0; e_rsp_v[n] = 0; e_rsp_val[n] = '0; e_rsp_err[n] = 0;
      end
      m_ptr = 0; m_rd_out = 0; m_rd_owner = 0; m_rd_first = 0; m_avail_at = 0;
      e_w_en = 0; e_r_en = 0; e_w_addr = '0; e_r_addr = '0; e_w_value = '0;
   endfunction

   // Consumes the inputs of the current cycle, predicts the next cycle.
   function automatic void model_step(input req_t q0, input req_t q1,
                                      input logic rv, input logic [VW-1:0] rval);
      req_t q [2];
      bit   old_v [2];
      int   g;
      q[0] = q0; q[1] = q1;
      old_v = m_slot_v;
      e_w_en = 0; e_r_en = 0;
      for (int n = 0; n < 2; n++) begin e_rsp_v[n] = 0; e_rsp_err[n] = 0; end

      g = -1;
      if (!m_rd_out && cyc >= m_avail_at) begin
         if (old_v[0] && old_v[1]) g = m_ptr;
         else if (old_v[0])        g = 0;
         else if (old_v[1])        g = 1;
      end

      for (int n = 0; n < 2; n++) begin
         if (q[n].w || q[n].r) begin
            if (old_v[n]) m_drop[n] = 1;
            else begin
               m_slot_v[n] = 1; m_slot_w[n] = q[n].w;
               m_slot_a[n] = q[n].addr; m_slot_d[n] = q[n].value;
            end
         end
      end

      if (g >= 0) begin
         m_slot_v[g] = 0;
         m_ptr = 1 - g;
         if (m_slot_w[g]) begin
            e_w_en = 1; e_w_addr = m_slot_a[g]; e_w_value = m_slot_d[g];
            m_avail_at = cyc + 2;
         end else begin
            e_r_en = 1; e_r_addr = m_slot_a[g];
            m_rd_out = 1; m_rd_owner = g; m_rd_first = cyc + 2;
         end
      end else if (m_rd_out && cyc >= m_rd_first) begin
         if (rv) begin
            e_rsp_v[m_rd_owner] = 1; e_rsp_val[m_rd_owner] = rval;
            m_rd_out = 0; m_avail_at = cyc + 1;
         end
`ifdef ARB_TIMEOUT_EN
         else if (cyc == m_rd_first + TO - 1) begin
            e_rsp_v[m_rd_owner] = 1; e_rsp_val[m_rd_owner] = '0;
            e_rsp_err[m_rd_owner] = 1;
            m_rd_out = 0; m_avail_at = cyc + 1;
         end
`endif
      end
      cyc++;
   endfunction

   task automatic compare_all();
      logic          rv_o  [2];
      logic [VW-1:0] val_o [2];
      logic          err_o [2];
      rv_o[0] = rsp0_valid; rv_o[1] = rsp1_valid;
      val_o[0] = rsp0_value; val_o[1] = rsp1_value;
      err_o[0] = rsp0_err; err_o[1] = rsp1_err;
      check("busy0", busy0, m_slot_v[0]);
      check("busy1", busy1, m_slot_v[1]);
      check("drop0", drop0, m_drop[0]);
      check("drop1", drop1, m_drop[1]);
      check("w_en", w_en, e_w_en);
      check("w_addr", w_addr, e_w_addr);
      check("w_value", w_value, e_w_value);
      check("r_en", r_en, e_r_en);
      check("r_addr", r_addr, e_r_addr);
      for (int n = 0; n < 2; n++) begin
         check($sformatf("rsp%0d_valid", n), rv_o[n], e_rsp_v[n]);
         if (e_rsp_v[n]) check($sformatf("rsp%0d_value", n), val_o[n], e_rsp_val[n]);
`ifdef ARB_TIMEOUT_EN
         if (e_rsp_v[n]) check($sformatf("rsp%0d_err", n), err_o[n], e_rsp_err[n]);
`else
         check($sformatf("rsp%0d_err", n), err_o[n], 1'b0);
`endif
      end
   endtask

   // One clock cycle: compare at the falling edge, then drive and predict.
   task automatic tick(input req_t q0, input req_t q1,
                       input logic rv, input logic [VW-1:0] rval);
      @(negedge clk);
      compare_all();
      req0_w_en = q0.w; req0_r_en = q0.r; req0_addr = q0.addr; req0_value = q0.value;
      req1_w_en = q1.w; req1_r_en = q1.r; req1_addr = q1.addr; req1_value = q1.value;
      r_valid = rv; r_value = rval;
      model_step(q0, q1, rv, rval);
   endtask

   function automatic req_t mk(input logic w, input logic r,
                               input logic [WW-1:0] a, input logic [VW-1:0] d);
      req_t q;
      q.w = w; q.r = r; q.addr = a; q.value = d;
      return q;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick('0, '0, 1'b0, '0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {busy0, busy1, drop0, drop1}, 4'h0);
      check({tag, "_rsp"}, {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}, 4'h0);
      check({tag, "_rspval"}, {rsp0_value, rsp1_value}, 64'h0);
      check({tag, "_wport"}, {w_en, w_addr, w_value}, '0);
      check({tag, "_rport"}, {r_en, r_addr}, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req0_w_en = 0; req0_r_en = 0; req0_addr = '0; req0_value = '0;
      req1_w_en = 0; req1_r_en = 0; req1_addr = '0; req1_value = '0;
      r_valid = 0; r_value = '0;
      #1;
      check_all_zero("reset");
      model_reset();
      idle(2);
      rst_n = 1'b1;

      // Single write: req0 0x03 / 0xDEADBEEF.
      tick(mk(1, 0, 8'h03, 32'hDEADBEEF), '0, 1'b0, '0);
      idle(1); check("wr_busy_t1", busy0, 1'b1);
      idle(1); check("wr_issue", {w_en, w_addr, w_value}, {1'b1, 8'h03, 32'hDEADBEEF});
               check("wr_busy_t2", busy0, 1'b0);
      idle(1); check("wr_one_pulse", w_en, 1'b0);

      // Single read: req1 0x05, data three cycles after o_r_en.
      tick('0, mk(0, 1, 8'h05, '0), 1'b0, '0);
      idle(2); check("rd_issue", {r_en, r_addr}, {1'b1, 8'h05});
      idle(2);
      tick('0, '0, 1'b1, 32'h12345678);
      idle(1); check("rd_rsp1", {rsp1_valid, rsp1_value}, {1'b1, 32'h12345678});
               check("rd_rsp0_quiet", rsp0_valid, 1'b0);

      // Contention twice; a lone req0 write in between leaves req1 favoured.
      tick(mk(1, 0, 8'h10, 32'hA0), mk(1, 0, 8'h20, 32'hB0), 1'b0, '0);
      idle(2); check("cont1_first", {w_en, w_addr}, {1'b1, 8'h10});
      idle(2); check("cont1_second", {w_en, w_addr}, {1'b1, 8'h20});
      idle(1);
      tick(mk(1, 0, 8'h30, 32'hC0), '0, 1'b0, '0);
      idle(3);
      tick(mk(1, 0, 8'h11, 32'hA1), mk(1, 0, 8'h21, 32'hB1), 1'b0, '0);
      idle(2); check("cont2_first", {w_en, w_addr}, {1'b1, 8'h21});
      idle(2); check("cont2_second", {w_en, w_addr}, {1'b1, 8'h11});
      idle(1);

      // Overflow: req0 pulses twice while req1's read waits.
      tick('0, mk(0, 1, 8'h40, '0), 1'b0, '0);
      idle(2);
      tick(mk(1, 0, 8'h50, 32'h55), '0, 1'b0, '0);
      tick(mk(1, 0, 8'h51, 32'h66), '0, 1'b0, '0);
      idle(1); check("ovf_drop0", drop0, 1'b1);
      tick('0, '0, 1'b1, 32'h0BADF00D);
      idle(1); check("ovf_rsp1", rsp1_valid, 1'b1);
      idle(1); check("ovf_issue", {w_en, w_addr, w_value}, {1'b1, 8'h50, 32'h55});
      idle(4); check("ovf_drop0_sticky", drop0, 1'b1);

`ifdef ARB_TIMEOUT_EN
      // Timeout: read with no data answers with err 8 cycles into WAIT_RD.
      tick(mk(0, 1, 8'h60, '0), '0, 1'b0, '0);
      idle(10);
      tick('0, '0, 1'b1, 32'hAAAA5555);
      check("to_rsp0", {rsp0_valid, rsp0_err, rsp0_value}, {1'b1, 1'b1, 32'h0});
      idle(1); check("to_late_ignored", rsp0_valid, 1'b0);
      idle(1);
`endif

      // Reset during WAIT_RD: outputs drop at once; late data is ignored.
      tick(mk(0, 1, 8'h70, '0), '0, 1'b0, '0);
      idle(3);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrd_reset");
      model_reset();
      idle(1);
      rst_n = 1'b1;
      tick('0, '0, 1'b1, 32'h5555AAAA);
      idle(1); check("midrd_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         req_t q [2];
         for (int n = 0; n < 2; n++) begin
            int sel;
            sel = $urandom_range(0, 7);
            q[n] = mk(sel == 0 || sel == 2, sel == 1 || sel == 2,
                      WW'($urandom), VW'($urandom));
         end
         tick(q[0], q[1], $urandom_range(0, 5) == 0, VW'($urandom));
      end
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
